dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
Sequencing controller between the pipeline's memory stage and the word-organised data memory; drives the sub-word load/store alignment unit (SL_UNIT).
- Loads: issues a word read, then returns the extracted and extended value.
- SB/SH: performs a read-modify-write, writing back the merged word produced by SL_UNIT.
- SW: performs a single write.
- Misaligned or illegal requests are rejected with an error response and never touch memory.

Parameters:
TIMEOUT, 16, max cycles to wait for mem_rvalid before aborting with error (>=1)
CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  input  1  clock, all state changes on rising edge
rstn  input  1  asynchronous active-low reset
req_valid  input  1  pipeline request valid
req_ready  output  1  controller accepts request; high only in IDLE
req_addr  input  32  byte address
req_access  input  4  access code, `LB/`LBU/`LH/`LHU/`LW/`SB/`SH/`SW from include/config.v
req_wdata  input  32  store data, low bits significant for SB/SH
resp_valid  output  1  response valid
resp_ready  input  1  pipeline accepts response
resp_rdata  output  32  load result; 0 for stores and errors
resp_err  output  1  misaligned, illegal code, or timeout
mem_en  output  1  memory access strobe, one cycle per access
mem_we  output  1  write enable, qualified by mem_en
mem_addr  output  32  word address, {req_addr[31:2],2'b00}
mem_wdata  output  32  write word
mem_rdata  input  32  read word, valid with mem_rvalid
mem_rvalid  input  1  read data valid, >=1 cycle after read mem_en
sl_addr  output  32  to SL_UNIT addr, latched request address
sl_access  output  4  to SL_UNIT dmem_access, latched code
sl_rd_in  output  32  to SL_UNIT rd_in, captured read word
sl_wd_in  output  32  to SL_UNIT wd_in, latched store data
sl_rd_out  input  32  from SL_UNIT, extended load value
sl_wd_out  input  32  from SL_UNIT, merged store word

Behaviour:
- Reset: state IDLE. req_ready=1. All of resp_valid, resp_err, resp_rdata, mem_en, mem_we, mem_addr, mem_wdata = 0. Latches (addr, access, wdata, rd buffer) and timeout counter = 0. Reset mid-operation aborts immediately; any pending memory read is dropped and a later mem_rvalid in IDLE is ignored.
- States: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RESP.
- IDLE: on req_valid&req_ready, latch addr/access/wdata, then classify:
  - Misaligned (LH/LHU/SH with addr[1:0]==3; LW/SW with addr[1:0]!=0) or unknown code -> RESP with err=1, rdata=0, no mem_en.
  - SW -> WR_ISSUE.
  - All loads, SB, SH -> RD_ISSUE.
- RD_ISSUE: mem_en=1, mem_we=0, for exactly one cycle. -> RD_WAIT; counter cleared.
- RD_WAIT:
  - On mem_rvalid, capture mem_rdata into the rd buffer (drives sl_rd_in). Loads -> RESP with resp_rdata = sl_rd_out (computed combinationally from the captured word, registered on entry to RESP). SB/SH -> WR_ISSUE.
  - Otherwise the counter increments; when it reaches TIMEOUT -> RESP with err=1, rdata=0.
  - mem_rvalid in the same cycle the counter reaches TIMEOUT: data wins, no error.
- WR_ISSUE: mem_en=1, mem_we=1 for one cycle. mem_wdata = sl_wd_out for SB/SH, latched wdata for SW. Writes complete in that cycle. -> RESP, rdata=0, err=0.
- RESP: resp_valid=1 with stable rdata/err until resp_ready. On the handshake cycle -> IDLE; resp_valid drops next cycle.
- req_ready=1 only in IDLE, so one request is outstanding at a time; there is no back-to-back acceptance while a response is pending.
- Latency, valid accept to resp_valid, with rvalid arriving R cycles after the read strobe:
  - SW: 2 cycles.
  - Load: R+2 cycles.
  - SB/SH: R+3 cycles.
  - Error without memory access: 1 cycle.
- mem_addr is held stable from the issue cycle through RESP. mem_en is never asserted outside RD_ISSUE/WR_ISSUE.

Test Plan:
- LB addr 0x1003, memory word 0x80FF_1234, R=1 -> one read at 0x1000; resp_rdata=0xFFFF_FF80, err=0, resp_valid 3 cycles after accept.
- SB addr 0x2001 wdata 0xAA, memory word 0x1122_3344 -> read then write at 0x2000, mem_wdata=0x1122_AA44; no second mem_en; resp_rdata=0.
- SW addr 0x3000 wdata 0xDEAD_BEEF -> single write cycle, no read; resp 2 cycles after accept. Then LW addr 0x3002 -> err=1, mem_en never asserted.
- LHU addr 0x4002 with mem_rvalid withheld -> err=1 exactly TIMEOUT cycles into RD_WAIT. Repeat with rvalid on cycle TIMEOUT -> data returned, err=0.
- resp_ready held low 5 cycles on an LW response -> resp_valid/rdata stable, req_ready=0 throughout; IDLE and req_ready=1 the cycle after the handshake.
- rstn asserted during RD_WAIT of an SH, then a late mem_rvalid -> outputs at reset values; no write issued; next request handled normally.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// Sequences pipeline load/store requests onto a word-wide data memory, using SL_UNIT for
// sub-word extraction and merge; one request outstanding, sub-word stores done as read-modify-write.
module dmem_access_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_access,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic [31:0] sl_addr,
  output logic [3:0]  sl_access,
  output logic [31:0] sl_rd_in,
  output logic [31:0] sl_wd_in,
  input  logic [31:0] sl_rd_out,
  input  logic [31:0] sl_wd_out
);

  localparam logic [3:0] ACC_LB  = 4'h0;
  localparam logic [3:0] ACC_LH  = 4'h1;
  localparam logic [3:0] ACC_LW  = 4'h2;
  localparam logic [3:0] ACC_LBU = 4'h4;
  localparam logic [3:0] ACC_LHU = 4'h5;
  localparam logic [3:0] ACC_SB  = 4'h8;
  localparam logic [3:0] ACC_SH  = 4'h9;
  localparam logic [3:0] ACC_SW  = 4'hA;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD_ISSUE = 3'd1;
  localparam logic [2:0] S_RD_WAIT  = 3'd2;
  localparam logic [2:0] S_WR_ISSUE = 3'd3;
  localparam logic [2:0] S_RESP     = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [3:0]       acc_q, acc_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdbuf_q, rdbuf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic req_legal;
  logic req_mis;
  logic acc_is_load;

  always_comb begin
    req_legal = 1'b1;
    req_mis   = 1'b0;
    case (req_access)
      ACC_LB, ACC_LBU, ACC_SB: req_mis = 1'b0;
      ACC_LH, ACC_LHU, ACC_SH: req_mis = (req_addr[1:0] == 2'b11);
      ACC_LW, ACC_SW:          req_mis = (req_addr[1:0] != 2'b00);
      default:                 req_legal = 1'b0;
    endcase
  end

  assign acc_is_load = acc_q inside {ACC_LB, ACC_LBU, ACC_LH, ACC_LHU, ACC_LW};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    acc_d   = acc_q;
    wdata_d = wdata_q;
    rdbuf_d = rdbuf_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          acc_d   = req_access;
          wdata_d = req_wdata;
          if (!req_legal || req_mis) begin
            state_d = S_RESP;
            err_d   = 1'b1;
            rdata_d = 32'h0;
          end else if (req_access == ACC_SW) begin
            state_d = S_WR_ISSUE;
          end else begin
            state_d = S_RD_ISSUE;
          end
        end
      end
      S_RD_ISSUE: begin
        state_d = S_RD_WAIT;
        cnt_d   = '0;
      end
      S_RD_WAIT: begin
        // Returning data takes priority over a timeout expiring in the same cycle.
        if (mem_rvalid) begin
          rdbuf_d = mem_rdata;
          if (acc_is_load) begin
            state_d = S_RESP;
            rdata_d = sl_rd_out;
            err_d   = 1'b0;
          end else begin
            state_d = S_WR_ISSUE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNT_W'(TIMEOUT)) begin
            state_d = S_RESP;
            err_d   = 1'b1;
            rdata_d = 32'h0;
          end
        end
      end
      S_WR_ISSUE: begin
        state_d = S_RESP;
        rdata_d = 32'h0;
        err_d   = 1'b0;
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
          rdata_d = 32'h0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      addr_q  <= 32'h0;
      acc_q   <= 4'h0;
      wdata_q <= 32'h0;
      rdbuf_q <= 32'h0;
      cnt_q   <= '0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      acc_q   <= acc_d;
      wdata_q <= wdata_d;
      rdbuf_q <= rdbuf_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  assign mem_en    = (state_q == S_RD_ISSUE) || (state_q == S_WR_ISSUE);
  assign mem_we    = (state_q == S_WR_ISSUE);
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = (state_q != S_WR_ISSUE) ? 32'h0 :
                     (acc_q == ACC_SW)       ? wdata_q : sl_wd_out;

  // Forward the returning word so the load result can be registered on the capture edge.
  assign sl_rd_in  = ((state_q == S_RD_WAIT) && mem_rvalid) ? mem_rdata : rdbuf_q;
  assign sl_addr   = addr_q;
  assign sl_access = acc_q;
  assign sl_wd_in  = wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: behavioural SL_UNIT stand-in, latency-programmable memory responder,
// directed scenarios plus randomized transactions against an arithmetic reference model.
module tb_dmem_access_ctrl;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 5;

  localparam logic [3:0] LB  = 4'h0;
  localparam logic [3:0] LH  = 4'h1;
  localparam logic [3:0] LW  = 4'h2;
  localparam logic [3:0] LBU = 4'h4;
  localparam logic [3:0] LHU = 4'h5;
  localparam logic [3:0] SB  = 4'h8;
  localparam logic [3:0] SH  = 4'h9;
  localparam logic [3:0] SW  = 4'hA;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_access;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rvalid;
  logic [31:0] sl_addr, sl_rd_in, sl_wd_in, sl_rd_out, sl_wd_out;
  logic [3:0]  sl_access;

  int checks;
  int errors;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_access(req_access), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .sl_addr(sl_addr), .sl_access(sl_access), .sl_rd_in(sl_rd_in), .sl_wd_in(sl_wd_in),
    .sl_rd_out(sl_rd_out), .sl_wd_out(sl_wd_out)
  );

  function automatic logic [31:0] ref_load(input logic [3:0] acc, input logic [31:0] addr,
                                           input logic [31:0] w);
    logic [31:0] s;
    s = w >> (int'(addr[1:0]) * 8);
    case (acc)
      LB:      return {{24{s[7]}}, s[7:0]};
      LBU:     return {24'h0, s[7:0]};
      LH:      return {{16{s[15]}}, s[15:0]};
      LHU:     return {16'h0, s[15:0]};
      LW:      return w;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] ref_merge(input logic [3:0] acc, input logic [31:0] addr,
                                            input logic [31:0] w, input logic [31:0] wd);
    logic [31:0] mask;
    int sh;
    sh   = int'(addr[1:0]) * 8;
    mask = (acc == SB) ? 32'hFF : (acc == SH) ? 32'hFFFF : 32'hFFFF_FFFF;
    mask = mask << sh;
    return (w & ~mask) | ((wd << sh) & mask);
  endfunction

  // Behavioural SL_UNIT.
  assign sl_rd_out = ref_load(sl_access, sl_addr, sl_rd_in);
  assign sl_wd_out = ref_merge(sl_access, sl_addr, sl_rd_in, sl_wd_in);

  // Memory responder: answers each read strobe rd_lat cycles later (rd_lat==0: never).
  int          rd_lat;
  logic [31:0] rd_word;
  int          pend_cnt;
  logic [31:0] pend_word;
  int          n_rd, n_wr;
  logic [31:0] last_rd_addr, last_wr_addr, last_wr_data;

  always @(negedge clk) begin
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = pend_word;
      end
    end
    if (mem_en === 1'b1 && mem_we === 1'b0) begin
      n_rd++;
      last_rd_addr = mem_addr;
      if (rd_lat > 0) begin
        pend_cnt  = rd_lat;
        pend_word = rd_word;
      end
    end
    if (mem_en === 1'b1 && mem_we === 1'b1) begin
      n_wr++;
      last_wr_addr = mem_addr;
      last_wr_data = mem_wdata;
    end
  end

  // Observations from the last transaction.
  int          o_lat, d_rd, d_wr;
  logic        o_valid, o_err, o_stable, o_ready_before, o_ready_after, o_valid_after;
  logic [31:0] o_rdata;

  task automatic run(input logic [3:0] acc, input logic [31:0] addr, input logic [31:0] wd,
                     input int r, input int hold);
    int base_rd, base_wr;
    rd_lat  = r;
    base_rd = n_rd;
    base_wr = n_wr;
    o_ready_before = req_ready;
    req_valid = 1'b1; req_access = acc; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_access = 4'($urandom); req_addr = $urandom; req_wdata = $urandom;
    o_lat = 1;
    while (resp_valid !== 1'b1 && o_lat < 200) begin
      @(posedge clk); #1;
      o_lat++;
    end
    o_valid = resp_valid; o_err = resp_err; o_rdata = resp_rdata; o_stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (resp_valid !== 1'b1 || resp_err !== o_err || resp_rdata !== o_rdata || req_ready !== 1'b0)
        o_stable = 1'b0;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    o_ready_after = req_ready;
    o_valid_after = resp_valid;
    d_rd = n_rd - base_rd;
    d_wr = n_wr - base_wr;
  endtask

  task automatic test_reset();
    rstn = 1'b0; req_valid = 1'b0; req_addr = 32'h0; req_access = 4'h0; req_wdata = 32'h0;
    resp_ready = 1'b0; rd_lat = 0; rd_word = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %b exp 1", req_ready); end
    checks++; if ({resp_valid, resp_err, mem_en, mem_we} !== 4'b0) begin errors++;
      $display("FAIL rst_ctrl got %b exp 0000", {resp_valid, resp_err, mem_en, mem_we}); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", resp_rdata); end
    checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin errors++;
      $display("FAIL rst_mem got addr %h wdata %h exp 0", mem_addr, mem_wdata); end
    checks++; if ({sl_addr, sl_rd_in, sl_wd_in, sl_access} !== 100'h0) begin errors++;
      $display("FAIL rst_latches got %h %h %h %h exp 0", sl_addr, sl_rd_in, sl_wd_in, sl_access); end
    rstn = 1'b1;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b exp 1", req_ready); end
  endtask

  task automatic test_lb();
    rd_word = 32'h80FF_1234;
    run(LB, 32'h0000_1003, 32'h0, 1, 0);
    checks++; if (o_ready_before !== 1'b1) begin errors++; $display("FAIL lb_ready got %b exp 1", o_ready_before); end
    checks++; if (o_rdata !== 32'hFFFF_FF80 || o_err !== 1'b0) begin errors++;
      $display("FAIL lb_resp got %h err %b exp ffffff80 err 0", o_rdata, o_err); end
    checks++; if (o_lat !== 3) begin errors++; $display("FAIL lb_latency got %0d exp 3", o_lat); end
    checks++; if (d_rd !== 1 || d_wr !== 0 || last_rd_addr !== 32'h1000) begin errors++;
      $display("FAIL lb_mem got rd %0d wr %0d addr %h exp 1 0 00001000", d_rd, d_wr, last_rd_addr); end
  endtask

  task automatic test_sb_rmw();
    rd_word = 32'h1122_3344;
    run(SB, 32'h0000_2001, 32'h0000_00AA, 1, 0);
    checks++; if (d_rd !== 1 || d_wr !== 1) begin errors++;
      $display("FAIL sb_accesses got rd %0d wr %0d exp 1 1", d_rd, d_wr); end
    checks++; if (last_wr_addr !== 32'h2000 || last_wr_data !== 32'h1122_AA44) begin errors++;
      $display("FAIL sb_write got %h@%h exp 1122aa44@00002000", last_wr_data, last_wr_addr); end
    checks++; if (o_rdata !== 32'h0 || o_err !== 1'b0 || o_lat !== 4) begin errors++;
      $display("FAIL sb_resp got %h err %b lat %0d exp 0 0 4", o_rdata, o_err, o_lat); end
  endtask

  task automatic test_sw_and_misaligned();
    run(SW, 32'h0000_3000, 32'hDEAD_BEEF, 1, 0);
    checks++; if (d_rd !== 0 || d_wr !== 1 || last_wr_data !== 32'hDEAD_BEEF || last_wr_addr !== 32'h3000) begin
      errors++; $display("FAIL sw_write got rd %0d wr %0d %h@%h exp 0 1 deadbeef@00003000",
                         d_rd, d_wr, last_wr_data, last_wr_addr); end
    checks++; if (o_lat !== 2 || o_err !== 1'b0) begin errors++;
      $display("FAIL sw_resp got lat %0d err %b exp 2 0", o_lat, o_err); end
    run(LW, 32'h0000_3002, 32'h0, 1, 0);
    checks++; if (o_err !== 1'b1 || o_rdata !== 32'h0 || o_lat !== 1) begin errors++;
      $display("FAIL lw_misaligned got err %b rdata %h lat %0d exp 1 0 1", o_err, o_rdata, o_lat); end
    checks++; if (d_rd !== 0 || d_wr !== 0) begin errors++;
      $display("FAIL lw_misaligned_mem got rd %0d wr %0d exp 0 0", d_rd, d_wr); end
  endtask

  task automatic test_timeout();
    rd_word = 32'h89AB_CDEF;
    run(LHU, 32'h0000_4002, 32'h0, 0, 0);
    checks++; if (o_err !== 1'b1 || o_rdata !== 32'h0 || o_lat !== TIMEOUT + 2) begin errors++;
      $display("FAIL timeout_err got err %b rdata %h lat %0d exp 1 0 %0d", o_err, o_rdata, o_lat, TIMEOUT + 2); end
    run(LHU, 32'h0000_4002, 32'h0, TIMEOUT, 0);
    checks++; if (o_err !== 1'b0 || o_rdata !== 32'h0000_89AB || o_lat !== TIMEOUT + 2) begin errors++;
      $display("FAIL timeout_edge_data got err %b rdata %h lat %0d exp 0 000089ab %0d", o_err, o_rdata, o_lat, TIMEOUT + 2); end
    run(LHU, 32'h0000_4002, 32'h0, TIMEOUT + 1, 0);
    checks++; if (o_err !== 1'b1 || o_rdata !== 32'h0) begin errors++;
      $display("FAIL timeout_late got err %b rdata %h exp 1 0", o_err, o_rdata); end
  endtask

  task automatic test_backpressure();
    rd_word = $urandom;
    run(LW, 32'h0000_5000, 32'h0, 2, 5);
    checks++; if (o_stable !== 1'b1) begin errors++; $display("FAIL bp_stable got %b exp 1", o_stable); end
    checks++; if (o_rdata !== rd_word || o_err !== 1'b0 || o_lat !== 4) begin errors++;
      $display("FAIL bp_resp got %h err %b lat %0d exp %h 0 4", o_rdata, o_err, o_lat, rd_word); end
    checks++; if (o_ready_after !== 1'b1 || o_valid_after !== 1'b0) begin errors++;
      $display("FAIL bp_after got ready %b valid %b exp 1 0", o_ready_after, o_valid_after); end
  endtask

  task automatic test_reset_mid();
    int base_wr;
    base_wr = n_wr;
    rd_word = 32'hCAFE_F00D;
    rd_lat  = 6;
    req_valid = 1'b1; req_access = SH; req_addr = 32'h0000_6002; req_wdata = 32'h1234;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rstn = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_en !== 1'b0 || mem_addr !== 32'h0) begin errors++;
      $display("FAIL midrst_outputs got ready %b valid %b en %b addr %h exp 1 0 0 0", req_ready, resp_valid, mem_en, mem_addr); end
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (8) begin @(posedge clk); #1; end
    checks++; if (n_wr !== base_wr || resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++;
      $display("FAIL midrst_late_rvalid got wr %0d valid %b ready %b exp %0d 0 1", n_wr, resp_valid, req_ready, base_wr); end
    checks++; if (sl_rd_in !== 32'h0) begin errors++; $display("FAIL midrst_rdbuf got %h exp 0", sl_rd_in); end
    rd_word = 32'h0BAD_F00D;
    run(LW, 32'h0000_6000, 32'h0, 2, 0);
    checks++; if (o_rdata !== 32'h0BAD_F00D || o_err !== 1'b0 || o_lat !== 4) begin errors++;
      $display("FAIL midrst_next got %h err %b lat %0d exp 0badf00d 0 4", o_rdata, o_err, o_lat); end
  endtask

  task automatic test_random();
    logic [31:0] ref_mem [256];
    logic [3:0]  codes [8];
    codes = '{LB, LH, LW, LBU, LHU, SB, SH, SW};
    for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
    for (int n = 0; n < 60; n++) begin
      logic [3:0]  acc;
      logic [31:0] addr, wd, exp_rdata, exp_wdata;
      int idx, r, size, exp_lat, exp_rd, exp_wr;
      bit legal, is_ld, exp_err;
      int k;
      k = $urandom_range(0, 8);
      if (k == 8) acc = ($urandom_range(0, 1) == 1) ? 4'h3 : 4'hF;
      else acc = codes[k];
      idx  = $urandom_range(0, 255);
      addr = (32'(idx) << 2) | 32'($urandom_range(0, 3));
      wd   = $urandom;
      r    = $urandom_range(1, 4);
      legal = (k != 8);
      is_ld = acc inside {LB, LBU, LH, LHU, LW};
      size  = (acc inside {LB, LBU, SB}) ? 1 : (acc inside {LH, LHU, SH}) ? 2 : 4;
      exp_err   = !legal || (int'(addr[1:0]) + size > 4);
      exp_rd    = (!exp_err && acc != SW) ? 1 : 0;
      exp_wr    = (!exp_err && !is_ld) ? 1 : 0;
      exp_lat   = exp_err ? 1 : (acc == SW) ? 2 : is_ld ? r + 2 : r + 3;
      exp_rdata = (!exp_err && is_ld) ? ref_load(acc, addr, ref_mem[idx]) : 32'h0;
      exp_wdata = (acc == SW) ? wd : ref_merge(acc, addr, ref_mem[idx], wd);
      rd_word = ref_mem[idx];
      run(acc, addr, wd, r, $urandom_range(0, 2));
      checks++; if (o_err !== exp_err || o_rdata !== exp_rdata) begin errors++;
        $display("FAIL rnd%0d_resp acc %h addr %h got %h err %b exp %h err %b", n, acc, addr, o_rdata, o_err, exp_rdata, exp_err); end
      checks++; if (o_lat !== exp_lat || d_rd !== exp_rd || d_wr !== exp_wr) begin errors++;
        $display("FAIL rnd%0d_timing acc %h got lat %0d rd %0d wr %0d exp %0d %0d %0d", n, acc, o_lat, d_rd, d_wr, exp_lat, exp_rd, exp_wr); end
      if (exp_wr == 1) begin
        checks++; if (last_wr_data !== exp_wdata || last_wr_addr !== {addr[31:2], 2'b00}) begin errors++;
          $display("FAIL rnd%0d_write got %h@%h exp %h@%h", n, last_wr_data, last_wr_addr, exp_wdata, {addr[31:2], 2'b00}); end
        ref_mem[idx] = exp_wdata;
      end
      if (exp_rd == 1) begin
        checks++; if (last_rd_addr !== {addr[31:2], 2'b00}) begin errors++;
          $display("FAIL rnd%0d_rdaddr got %h exp %h", n, last_rd_addr, {addr[31:2], 2'b00}); end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_lb();
    test_sb_rmw();
    test_sw_and_misaligned();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, %0d checks %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
